// File: rtl/capture_pkg.sv
// Shared defaults and sizing helpers for the switch code capture block.
package capture_pkg;

    localparam int DEF_WIDTH           = 8;
    localparam int DEF_DEPTH           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // Bits needed to hold values 0..n; never narrower than one bit.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/code_fifo.sv
// First-word-fall-through FIFO: dout always shows the entry at the read pointer.
module code_fifo
    import capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == COUNT_FULL);
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: storage is reset too, because the head code must read 0 straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/switch_code_capture.sv
// Synchronises and debounces a switch bank, turns 0->non-zero transitions into
// press events and queues the pressed codes for the control logic.
module switch_code_capture
    import capture_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              sw,
    input  logic                          consume,
    input  logic                          clear_overflow,
    output logic [WIDTH-1:0]              code,
    output logic                          code_valid,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow
);

    localparam int DW = count_width(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] CNT_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_prev_q, stable_prev_d;
    logic             press_q, press_d;
    logic [WIDTH-1:0] press_code_q, press_code_d;
    logic             overflow_q, overflow_d;
    logic             fifo_full, fifo_empty;

    always_comb begin
        s1_d          = sw;
        s2_d          = s1_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        stable_d      = stable_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Only a rise out of all-zero is a press; release re-arms detection.
        stable_prev_d = stable_q;
        press_d       = (stable_q != '0) && (stable_prev_q == '0);
        press_code_d  = stable_q;
        // A full FIFO still accepts the press when the head is popped this cycle.
        if (press_q && fifo_full && !consume) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q          <= '0;
            s2_q          <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            press_q       <= 1'b0;
            press_code_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            press_q       <= press_d;
            press_code_q  <= press_code_d;
            overflow_q    <= overflow_d;
        end
    end

    code_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_code_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (press_q),
        .pop   (consume),
        .din   (press_code_q),
        .dout  (code),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign code_valid = !fifo_empty;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_switch_code_capture.sv
// Self-checking bench for switch_code_capture: directed scenarios, a vector
// table and a randomized run against a sample-window reference model.
module tb_switch_code_capture;
    import capture_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int D  = DEF_DEPTH;
    localparam int DC = DEF_DEBOUNCE_CYCLES;
    localparam int CW = count_width(D);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  sw = '0;
    logic          consume = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [W-1:0]  code;
    logic          code_valid;
    logic [CW-1:0] count;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    switch_code_capture #(
        .WIDTH           (W),
        .DEPTH           (D),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sw             (sw),
        .consume        (consume),
        .clear_overflow (clear_overflow),
        .code           (code),
        .code_valid     (code_valid),
        .count          (count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] sw;
        logic         consume;
        logic         clr;
        int           cycles;
        int           exp_count;
        logic         exp_ovf;
        logic [W-1:0] exp_code;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_consume();
        consume = 1'b1;
        cyc(1);
        consume = 1'b0;
    endtask

    task automatic press_pair(input logic [W-1:0] v);
        sw = v;
        cyc(12);
        sw = '0;
        cyc(12);
    endtask

    function automatic vec_t mk(input string name, input logic [W-1:0] s, input logic c,
                                input logic clr, input int cycles, input int ec,
                                input logic eo, input logic [W-1:0] ecode);
        vec_t v;
        v.name = name; v.sw = s; v.consume = c; v.clr = clr; v.cycles = cycles;
        v.exp_count = ec; v.exp_ovf = eo; v.exp_code = ecode;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference model state for the randomized run
    logic [W-1:0] hist[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] m_st, m_st_prev, m_pr_val, new_val, cur;
    bit           m_pr, m_ovf, new_pr, all_eq, drop;
    int           hold_left;

    initial begin
        // Reset state
        cyc(3);
        check("rst_count", count, 0);
        check("rst_valid", code_valid, 0);
        check("rst_code", code, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b1;
        cyc(1);

        // Single press latency: sampled at edge 0, valid after edge 8
        sw = 8'h41;
        cyc(8);
        check("lat_not_yet", code_valid, 0);
        cyc(1);
        check("lat_valid", code_valid, 1);
        check("lat_code", code, 8'h41);
        check("lat_count", count, 1);
        pulse_consume();
        check("pop_valid", code_valid, 0);
        check("pop_count", count, 0);
        sw = '0;
        cyc(12);

        // Bounce rejection
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 8'h05 : 8'h00;
            cyc(2);
        end
        sw = 8'h05;
        cyc(8);
        check("bounce_early", count, 0);
        cyc(1);
        check("bounce_count", count, 1);
        check("bounce_code", code, 8'h05);
        cyc(10);
        check("bounce_once", count, 1);
        pulse_consume();
        sw = '0;
        cyc(12);

        // Vector table: no re-press without release, fill, overflow, drain, clear
        vecs.push_back(mk("nr_03",   8'h03, 0, 0, 20, 1, 0, 8'h03));
        vecs.push_back(mk("nr_07",   8'h07, 0, 0, 20, 1, 0, 8'h03));
        vecs.push_back(mk("nr_rel",  8'h00, 0, 0, 20, 1, 0, 8'h03));
        vecs.push_back(mk("nr_07b",  8'h07, 0, 0, 20, 2, 0, 8'h03));
        vecs.push_back(mk("nr_pop1", 8'h00, 1, 0, 12, 1, 0, 8'h07));
        vecs.push_back(mk("nr_pop2", 8'h00, 1, 0, 2,  0, 0, 8'h00));
        vecs.push_back(mk("fill_01", 8'h01, 0, 0, 12, 1, 0, 8'h01));
        vecs.push_back(mk("rel_01",  8'h00, 0, 0, 12, 1, 0, 8'h01));
        vecs.push_back(mk("fill_02", 8'h02, 0, 0, 12, 2, 0, 8'h01));
        vecs.push_back(mk("rel_02",  8'h00, 0, 0, 12, 2, 0, 8'h01));
        vecs.push_back(mk("fill_03", 8'h03, 0, 0, 12, 3, 0, 8'h01));
        vecs.push_back(mk("rel_03",  8'h00, 0, 0, 12, 3, 0, 8'h01));
        vecs.push_back(mk("fill_04", 8'h04, 0, 0, 12, 4, 0, 8'h01));
        vecs.push_back(mk("rel_04",  8'h00, 0, 0, 12, 4, 0, 8'h01));
        vecs.push_back(mk("ovf_05",  8'h05, 0, 0, 12, 4, 1, 8'h01));
        vecs.push_back(mk("rel_05",  8'h00, 0, 0, 12, 4, 1, 8'h01));
        vecs.push_back(mk("drain_1", 8'h00, 1, 0, 2,  3, 1, 8'h02));
        vecs.push_back(mk("drain_2", 8'h00, 1, 0, 2,  2, 1, 8'h03));
        vecs.push_back(mk("drain_3", 8'h00, 1, 0, 2,  1, 1, 8'h04));
        vecs.push_back(mk("drain_4", 8'h00, 1, 0, 2,  0, 1, 8'h00));
        vecs.push_back(mk("clr_ovf", 8'h00, 0, 1, 2,  0, 0, 8'h00));
        foreach (vecs[i]) begin
            sw = vecs[i].sw;
            consume = vecs[i].consume;
            clear_overflow = vecs[i].clr;
            cyc(1);
            consume = 1'b0;
            clear_overflow = 1'b0;
            cyc(vecs[i].cycles - 1);
            check({vecs[i].name, "_count"}, count, vecs[i].exp_count);
            check({vecs[i].name, "_valid"}, code_valid, (vecs[i].exp_count != 0));
            check({vecs[i].name, "_ovf"}, overflow, vecs[i].exp_ovf);
            if (vecs[i].exp_count != 0) check({vecs[i].name, "_code"}, code, vecs[i].exp_code);
        end

        // Simultaneous push and pop while full
        for (int i = 1; i <= 4; i++) press_pair(W'(i));
        check("sim_full", count, 4);
        sw = 8'h09;
        cyc(8);
        check("sim_pre_count", count, 4);
        check("sim_pre_code", code, 8'h01);
        consume = 1'b1;
        cyc(1);
        consume = 1'b0;
        check("sim_count", count, 4);
        check("sim_ovf", overflow, 0);
        check("sim_code_02", code, 8'h02);
        pulse_consume();
        check("sim_code_03", code, 8'h03);
        pulse_consume();
        check("sim_code_04", code, 8'h04);
        pulse_consume();
        check("sim_code_09", code, 8'h09);
        pulse_consume();
        check("sim_empty", code_valid, 0);
        sw = '0;
        cyc(12);

        // Asynchronous reset mid-operation
        press_pair(8'h11);
        press_pair(8'h22);
        press_pair(8'h33);
        check("mid_count", count, 3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_valid", code_valid, 0);
        check("arst_code", code, 0);
        check("arst_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        sw = 8'h5a;
        cyc(9);
        check("post_rst_count", count, 1);
        check("post_rst_code", code, 8'h5a);
        pulse_consume();
        sw = '0;
        cyc(12);

        // Randomized run against the reference model
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        hist.delete();
        mq.delete();
        for (int i = 0; i < DC + 3; i++) hist.push_back('0);
        m_st = '0; m_st_prev = '0; m_pr = 0; m_pr_val = '0; m_ovf = 0;
        hold_left = 0; cur = '0;
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            check("rnd_count", count, mq.size());
            check("rnd_valid", code_valid, (mq.size() != 0));
            check("rnd_ovf", overflow, m_ovf);
            if (mq.size() != 0) check("rnd_code", code, mq[0]);
            if (hold_left == 0) begin
                cur = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(1, 255));
                hold_left = $urandom_range(1, 10);
            end
            hold_left--;
            sw = cur;
            consume = ($urandom_range(0, 3) == 0);
            clear_overflow = ($urandom_range(0, 7) == 0);
            // Queue effect of the coming edge: pop first, then the pending press
            if (consume && mq.size() != 0) void'(mq.pop_front());
            drop = 0;
            if (m_pr) begin
                if (mq.size() < D) mq.push_back(m_pr_val);
                else drop = 1;
            end
            if (drop) m_ovf = 1;
            else if (clear_overflow) m_ovf = 0;
            // A press follows one edge after stable leaves all-zero
            new_pr = (m_st != '0) && (m_st_prev == '0);
            new_val = m_st;
            hist.push_back(sw);
            void'(hist.pop_front());
            // Stable takes a value seen on DC+1 consecutive samples ending two edges back
            all_eq = 1;
            for (int k = 1; k <= DC; k++) if (hist[k] != hist[0]) all_eq = 0;
            m_st_prev = m_st;
            if (all_eq) m_st = hist[0];
            m_pr = new_pr;
            m_pr_val = new_val;
        end
        consume = 1'b0;
        clear_overflow = 1'b0;
        @(negedge clk);
        check("rnd_final_count", count, mq.size());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
